// File: rtl/p2s_pkg.sv
// Shared definitions for the P2S serializer and the S2P receiver.
//   P2S_N   : default word width used by both sides of the loopback.
//   state_e : receiver word-framing states (idle, data shift, parity bit).
package p2s_pkg;

    localparam int unsigned P2S_N = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2
    } state_e;

endpackage

// File: rtl/s2p_shift.sv
// N-bit serial-in shift register with bit counter for the S2P receiver.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of counter and register (wins over shift_en)
//   shift_en   : take bit_in on this edge
//   bit_in     : serial data bit
//   word       : current register contents
//   word_next  : contents after inserting bit_in (the completed word when full is high)
//   full       : strobe, high in the cycle whose edge samples the N-th bit
module s2p_shift
    import p2s_pkg::*;
#(
    parameter int unsigned N         = P2S_N,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [N-1:0] word,
    output logic [N-1:0] word_next,
    output logic         full
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    shreg_q;
    logic [CntW-1:0] cnt_q;

    // MSB-first: bits enter at [0] and the first bit ends in [N-1] after N shifts.
    // LSB-first: bits enter at [N-1] and the first bit ends in [0].
    always_comb begin
        if (MSB_FIRST) begin
            word_next = {shreg_q[N-2:0], bit_in};
        end else begin
            word_next = {bit_in, shreg_q[N-1:1]};
        end
    end

    assign full = shift_en && (cnt_q == CntW'(N - 1));
    assign word = shreg_q;

    // The register is not cleared on completion: the next word overwrites it bit by
    // bit, and the parity stage needs the finished word held while the parity bit arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= word_next;
            cnt_q   <= full ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: rebuilds N-bit words from the p2s ser_out/valid stream
// and offers them on a registered valid/ready output.
// Optional feature: define S2P_PARITY_EN to expect one even-parity bit after each word.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous clear of any partial word (outputs untouched)
//   ser_in, ser_valid   : serial bit and its qualifier
//   par_out, out_valid  : last completed word and its valid flag
//   out_ready           : consumer accepts on out_valid & out_ready
//   overrun             : one-cycle pulse when a completed word is dropped
//   parity_err          : parity mismatch of the held word (0 without S2P_PARITY_EN)
module s2p_rx
    import p2s_pkg::*;
#(
    parameter int unsigned N         = P2S_N,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic [N-1:0] par_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    output logic         parity_err
);

    state_e       state_q, state_d;
    logic         shift_en;
    logic         full;
    logic [N-1:0] word, word_next;
    logic         done;
    logic [N-1:0] done_word;

    logic [N-1:0] par_out_q, par_out_d;
    logic         out_valid_q, out_valid_d;
    logic         overrun_q, overrun_d;

`ifdef S2P_PARITY_EN
    logic         done_perr;
    logic         perr_q, perr_d;
    // The parity bit is not shifted into the data register.
    assign shift_en = ser_valid && !clr && (state_q != StPar);
`else
    assign shift_en = ser_valid && !clr;
`endif

    s2p_shift #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift_en  (shift_en),
        .bit_in    (ser_in),
        .word      (word),
        .word_next (word_next),
        .full      (full)
    );

    // Word framing
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        done_word = word_next;
`ifdef S2P_PARITY_EN
        done_perr = 1'b0;
`endif
        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StShift: begin
                    if (full) begin
`ifdef S2P_PARITY_EN
                        state_d = StPar;
`else
                        done    = 1'b1;
                        state_d = StIdle;
`endif
                    end else if (ser_valid) begin
                        state_d = StShift;
                    end
                end
                StPar: begin
                    done_word = word;
`ifdef S2P_PARITY_EN
                    if (ser_valid) begin
                        done      = 1'b1;
                        done_perr = (^word) ^ ser_in;
                        state_d   = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output handshake and overrun
    always_comb begin
        par_out_d   = par_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
`ifdef S2P_PARITY_EN
        perr_d      = perr_q;
`endif
        if (done) begin
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                // Covers the same-edge case: the old word is consumed and the new one loads.
                par_out_d   = done_word;
                out_valid_d = 1'b1;
`ifdef S2P_PARITY_EN
                perr_d      = done_perr;
`endif
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            par_out_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_out_q   <= par_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef S2P_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign par_out   = par_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_s2p_rx.sv
// Self-checking bench for s2p_rx: directed scenarios plus a randomized stream,
// all compared against a bit-queue reference model.
module tb_s2p_rx;
    import p2s_pkg::*;

    localparam int unsigned N   = P2S_N;
    localparam bit          MSB = 1'b1;
`ifdef S2P_PARITY_EN
    localparam int unsigned WB = N + 1;
`else
    localparam int unsigned WB = N;
`endif

    logic         clk = 1'b0;
    logic         rst_n, clr, ser_in, ser_valid, out_ready;
    logic [N-1:0] par_out;
    logic         out_valid, overrun, parity_err;

    always #5 clk = ~clk;

    s2p_rx #(
        .N         (N),
        .MSB_FIRST (MSB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .par_out    (par_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;
    int unsigned cyc    = 0;

    // Reference model: received bits are collected in a queue and turned into a word
    // once a full frame has arrived.
    bit           m_bits[$];
    logic [N-1:0] m_par;
    logic         m_valid, m_ovr, m_perr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_par   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic b, input logic r, input logic c);
        logic [N-1:0] w;
        logic         pe;
        bit           done;
        done  = 0;
        w     = '0;
        pe    = 1'b0;
        m_ovr = 1'b0;
        if (c) begin
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() == WB) begin
                for (int i = 0; i < N; i++) begin
                    if (MSB) w[N-1-i] = m_bits[i];
                    else     w[i]     = m_bits[i];
                end
`ifdef S2P_PARITY_EN
                pe = (^w) != m_bits[N];
`endif
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_valid && !r) begin
                m_ovr = 1'b1;
            end else begin
                m_par   = w;
                m_perr  = pe;
                m_valid = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic b, input logic r, input logic c);
        ser_valid = v;
        ser_in    = b;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        model_edge(v, b, r, c);
        cyc++;
        #1;
        chk("par_out", par_out, m_par);
        chk("out_valid", out_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        chk("parity_err", parity_err, m_perr);
    endtask

    // Sends one frame; r_last is the ready value on the completing edge.
    task automatic send_word(input logic [N-1:0] w, input logic r_body, input logic r_last,
                             input logic flip_par);
        for (int i = 0; i < N; i++) begin
            logic rr;
            rr = (i == N - 1 && WB == N) ? r_last : r_body;
            step(1'b1, MSB ? w[N-1-i] : w[i], rr, 1'b0);
        end
`ifdef S2P_PARITY_EN
        step(1'b1, (^w) ^ flip_par, r_last, 1'b0);
`else
        if (flip_par) chk("no_parity_flip", 1'b0, 1'b1);
`endif
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    int unsigned t0, lat_loop, lat_pause;
    logic [N-1:0] w;

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_par_out", par_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_parity_err", parity_err, 0);
        rst_n = 1'b1;

        // Loopback word with continuous valid.
        t0 = cyc;
        send_word(32'hA5A50F0F, 1'b0, 1'b0, 1'b0);
        lat_loop = cyc - t0;
        chk("loop_valid", out_valid, 1);
        chk("loop_word", par_out, 32'hA5A50F0F);
        chk("loop_latency", lat_loop, WB);
        drain();

        // Pause for 5 cycles after bit 10.
        w  = 32'h12345678;
        t0 = cyc;
        for (int i = 0; i < 10; i++) step(1'b1, w[N-1-i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        for (int i = 10; i < N; i++) step(1'b1, w[N-1-i], 1'b0, 1'b0);
`ifdef S2P_PARITY_EN
        step(1'b1, ^w, 1'b0, 1'b0);
`endif
        lat_pause = cyc - t0;
        chk("pause_word", par_out, 32'h12345678);
        chk("pause_valid", out_valid, 1);
        chk("pause_latency", lat_pause, lat_loop + 5);
        drain();

        // Overrun: second word is dropped.
        send_word(32'h11111111, 1'b0, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_keep", par_out, 32'h11111111);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_one_cycle", overrun, 0);
        drain();

        // Ready arrives exactly on the completing edge of the next word.
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        chk("same_edge_valid", out_valid, 1);
        chk("same_edge_word", par_out, 32'hDEADBEEF);
        chk("same_edge_no_ovr", overrun, 0);
        drain();
        chk("same_edge_drained", out_valid, 0);

        // Asynchronous reset after 16 bits.
        send_word(32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_par_out", par_out, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_parity_err", parity_err, 0);
        #1;
        rst_n = 1'b1;

        // Clear after 16 bits: outputs untouched, next frame clean.
        send_word(32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_valid_kept", out_valid, 1);
        chk("clr_word_kept", par_out, 32'h5A5A5A5A);
        drain();
        send_word(32'h0F1E2D3C, 1'b0, 1'b0, 1'b0);
        chk("clr_next_word", par_out, 32'h0F1E2D3C);
        chk("clr_next_valid", out_valid, 1);
        drain();

`ifdef S2P_PARITY_EN
        send_word(32'h00000001, 1'b1, 1'b1, 1'b0);
        chk("par_good", parity_err, 0);
        send_word(32'h00000001, 1'b1, 1'b1, 1'b1);
        chk("par_bad", parity_err, 1);
        drain();
`endif

        // Randomized stream.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(63) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/s2p_rx.md
# s2p_rx

Serial-to-parallel receiver sitting directly downstream of `p2s`. It consumes the one-bit `ser_out`/`valid` stream and reassembles N-bit words. Each completed word is presented on a registered output with a valid/ready handshake toward the consuming RISC-V stage. It closes the P2S loopback path, so words can be checked end to end.

## Interface
Parameters:
- `N`, 32: word width in bits.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `par_out[N-1]`; 0 means it lands in `par_out[0]`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear; discards any partial word and returns to IDLE.
- `ser_in`  in  1  serial data bit; connects to `p2s.ser_out`.
- `ser_valid`  in  1  `ser_in` is sampled only while this is high; connects to `p2s.valid`.
- `par_out`  out  N  last completed word.
- `out_valid`  out  1  `par_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word on a cycle where `out_valid & out_ready`.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped.
- `parity_err`  out  1  parity check result for the current word (see Configuration).

## Operation
- Reset: `par_out`=0, `out_valid`=0, `overrun`=0, `parity_err`=0, shift register=0, bit counter=0, state=IDLE.
- States and transitions:
  - IDLE → SHIFT on the first cycle with `ser_valid`=1.
  - SHIFT → back to the start of a new word after N sampled bits.
  - With `S2P_PARITY_EN`, the word goes SHIFT → PAR after N sampled bits, and PAR → IDLE after one more sampled bit.
- Sampling:
  - A bit is taken on each rising edge with `ser_valid`=1; the counter increments.
  - `ser_valid`=0 pauses reception: counter and shift register hold, with no timeout.
- Word completion happens on the edge sampling the last bit (data bit N, or the parity bit when enabled):
  - The completed word is copied into `par_out`.
  - `out_valid` is set and the counter returns to 0.
  - Back-to-back words need no idle cycle.
- Handshake:
  - `out_valid` stays high with `par_out` stable until `out_valid & out_ready`.
  - On that edge `out_valid` clears unless a new word completes on the same edge.
  - If a new word completes on the same edge, the new word loads and `out_valid` stays 1.
- Overrun: a word completes while `out_valid`=1 and `out_ready`=0.
  - The new word is dropped and `par_out` keeps the old word.
  - `overrun` pulses for one cycle.
- `clr` has priority over sampling. It zeroes the counter and shift register and forces IDLE; `par_out`/`out_valid` are untouched.
- Reset asserted mid-word: immediate return to reset values; the partial word is lost.

## Timing
- Latency: `out_valid` is high in the cycle after the edge that samples the last bit.
- Pure-stream word period: N cycles, or N+1 with parity.
- No combinational path from inputs to outputs; all outputs are registered.
- `out_ready` may be held high permanently. In that case each word is visible for exactly one cycle if the next word follows immediately.

## Configuration
- `S2P_PARITY_EN` defined:
  - Each word is followed by one even-parity bit (XOR of the N data bits).
  - `parity_err` is registered together with `par_out`: 1 if the received parity bit mismatches.
  - It is valid while `out_valid`=1.
- `S2P_PARITY_EN` undefined:
  - There is no PAR state; exactly N bits make a word.
  - `parity_err` is tied to 0.

## Structure
- Shared package `p2s_pkg` holds:
  - the state enum (IDLE, SHIFT, PAR);
  - the default word width constant `P2S_N` = 32, used by both `p2s` and `s2p_rx`.
- One natural sub-module, `s2p_shift`: the N-bit shift register with MSB/LSB insertion and bit counter, exposing a `full` strobe.
- The handshake and overrun logic stay in `s2p_rx`.

## Test plan
- Loopback: `p2s` loaded with 0xA5A50F0F, `ser_valid` continuous.
  - Required: `out_valid` rises one cycle after the 32nd sampled bit, with `par_out`=0xA5A50F0F.
- Pause: drop `ser_valid` for 5 cycles after bit 10 of 0x12345678.
  - Required: the word is still received as 0x12345678, 5 cycles later than the unpaused case.
- Overrun: `out_ready`=0 while two words arrive (0x11111111, then 0x22222222).
  - Required: `par_out` stays 0x11111111, and `overrun` pulses once on completion of the second word.
- Same-edge handshake: `out_ready`=1 exactly on the edge where the next word 0xDEADBEEF completes.
  - Required: `out_valid` stays 1 and `par_out`=0xDEADBEEF.
- Reset/clear: assert `rst_n`=0 after 16 bits.
  - Required: all outputs read 0 immediately.
  - Repeat using `clr` instead: `out_valid` and `par_out` are unchanged, and the next 32 bits form a clean word.
- Parity (`S2P_PARITY_EN`): send 0x00000001 with parity bit 1, then 0x00000001 with parity bit 0.
  - Required: `parity_err`=0 for the first word and 1 for the second.
